// File: rtl/denise_colortable_ctrl.sv
// Colour-table write controller: snoops COLORxx/BPLCON3 register writes, queues them,
// and folds them into the 24-bit colour RAM around pixel lookups, which always win.
module denise_colortable_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr,
    input  logic [7:0]  reg_addr,
    input  logic [15:0] reg_data,
    input  logic        pix_rd,
    input  logic [7:0]  pix_index,
    output logic        pix_valid,
    output logic [23:0] pix_rgb,
    output logic        ram_enable,
    output logic        ram_wren,
    output logic [7:0]  ram_rdaddress,
    output logic [7:0]  ram_wraddress,
    output logic [31:0] ram_data,
    output logic [3:0]  ram_byteena,
    input  logic [31:0] ram_q,
    output logic        ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    typedef struct packed {
        logic        loct;
        logic [7:0]  index;
        logic [11:0] rgb;
    } entry_t;

    entry_t        fifo_q [FIFO_DEPTH];
    entry_t        fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [2:0]    bank_q, bank_d;
    logic          loct_q, loct_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    state_q, state_d;
    entry_t        work_q, work_d;
    logic [11:0]   old_hi_q, old_hi_d;
    logic          pix_valid_q, pix_valid_d;

    logic          is_color, push, pop;
    logic [23:0]   wr_rgb;
    logic          unused_bits;

    assign unused_bits = ^{ram_q[31:24], reg_data[12], reg_data[10]};

    always_comb begin
        bank_d      = bank_q;
        loct_d      = loct_q;
        ovf_d       = ovf_q;
        state_d     = state_q;
        work_d      = work_q;
        old_hi_d    = old_hi_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pix_valid_d = pix_rd;

        if (reg_wr && reg_addr == 8'h83) begin
            bank_d = reg_data[15:13];
            loct_d = reg_data[9];
        end

        // A pop in the same cycle frees the head slot, so a full queue still accepts.
        is_color = reg_wr && (reg_addr[7:5] == 3'b110);
        pop      = (state_q == S_IDLE) && (count_q != '0);
        push     = is_color && ((count_q != DEPTH_C) || pop);
        if (is_color && !push)
            ovf_d = 1'b1;

        if (push) begin
            fifo_d[wr_ptr_q] = '{loct: loct_q, index: {bank_q, reg_addr[4:0]}, rgb: reg_data[11:0]};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

        case (state_q)
            S_IDLE: if (pop) begin
                work_d  = fifo_q[rd_ptr_q];
                state_d = fifo_q[rd_ptr_q].loct ? S_RD : S_WR;
            end
            S_RD:   if (!pix_rd) state_d = S_CAP;
            S_CAP: begin
                // ram_q still holds the RD-cycle read even if a pixel read is issued now.
                old_hi_d = {ram_q[23:20], ram_q[15:12], ram_q[7:4]};
                state_d  = S_WR;
            end
            default: if (!pix_rd) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (work_q.loct)
            wr_rgb = {old_hi_q[11:8], work_q.rgb[11:8],
                      old_hi_q[7:4],  work_q.rgb[7:4],
                      old_hi_q[3:0],  work_q.rgb[3:0]};
        else
            wr_rgb = {work_q.rgb[11:8], work_q.rgb[11:8],
                      work_q.rgb[7:4],  work_q.rgb[7:4],
                      work_q.rgb[3:0],  work_q.rgb[3:0]};
    end

    assign ram_enable    = 1'b1;
    assign ram_wren      = (state_q == S_WR) && !pix_rd && !reset;
    assign ram_rdaddress = pix_rd ? pix_index : work_q.index;
    assign ram_wraddress = work_q.index;
    assign ram_data      = {8'h00, wr_rgb};
    assign ram_byteena   = 4'b0111;
    assign pix_valid     = pix_valid_q;
    assign pix_rgb       = pix_valid_q ? ram_q[23:0] : 24'h0;
    assign ovf           = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bank_q      <= '0;
            loct_q      <= 1'b0;
            ovf_q       <= 1'b0;
            work_q      <= '0;
            old_hi_q    <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            bank_q      <= bank_d;
            loct_q      <= loct_d;
            ovf_q       <= ovf_d;
            work_q      <= work_d;
            old_hi_q    <= old_hi_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    // Queue storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk)
        fifo_q <= fifo_d;

endmodule

// File: tb/tb_denise_colortable_ctrl.sv
// Bench for denise_colortable_ctrl: RAM model, a colour-table shadow plus pending-write
// scoreboard as reference, directed scenarios and a randomized phase.
module tb_denise_colortable_ctrl;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_wr = 1'b0;
    logic [7:0]  reg_addr = '0;
    logic [15:0] reg_data = '0;
    logic        pix_rd = 1'b0;
    logic [7:0]  pix_index = '0;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic        ram_enable, ram_wren;
    logic [7:0]  ram_rdaddress, ram_wraddress;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_q = '0;
    logic        ovf;

    denise_colortable_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
        .pix_rd(pix_rd), .pix_index(pix_index), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .ram_enable(ram_enable), .ram_wren(ram_wren), .ram_rdaddress(ram_rdaddress),
        .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_byteena(ram_byteena),
        .ram_q(ram_q), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Colour RAM: 1-cycle read latency, read suppressed during a write.
    logic        ram_clear = 1'b1;
    logic [31:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteena[b]) ram_mem[ram_wraddress][b*8 +: 8] <= ram_data[b*8 +: 8];
        end else begin
            ram_q <= ram_mem[ram_rdaddress];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected table contents and accepted-but-unwritten entries.
    logic [23:0] shadow [256];
    logic [20:0] exp_q [$];
    int          pending = 0;
    logic        m_ovf = 1'b0, m_loct = 1'b0, prev_rd = 1'b0;
    logic [2:0]  m_bank = '0;
    logic [23:0] exp_rgb = '0;
    int          wr_count = 0, n_pv = 0;
    logic [7:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [23:0] last_rgb = '0;

    function automatic logic [23:0] merge(input logic [20:0] e, input logic [23:0] old);
        logic [3:0] r, g, b;
        r = e[11:8]; g = e[7:4]; b = e[3:0];
        if (e[20]) return {old[23:20], r, old[15:12], g, old[7:4], b};
        return {r, r, g, g, b, b};
    endfunction

    always @(negedge clk) begin
        logic [20:0] e;
        logic [23:0] nv;
        if (ram_clear)
            for (int i = 0; i < 256; i++) shadow[i] = '0;
        check("ram_enable", 32'(ram_enable), 32'd1);
        if (reset) begin
            check("wren_in_reset", 32'(ram_wren), 32'd0);
            exp_q.delete();
            pending = 0; m_ovf = 0; m_bank = 0; m_loct = 0; prev_rd = 0;
        end else begin
            check("pix_valid", 32'(pix_valid), 32'(prev_rd));
            if (prev_rd) check("pix_rgb", 32'(pix_rgb), 32'(exp_rgb));
            if (pix_valid) begin last_rgb = pix_rgb; n_pv++; end
            check("ovf", 32'(ovf), 32'(m_ovf));
            if (pix_rd) begin
                check("wren_during_pix", 32'(ram_wren), 32'd0);
                check("rdaddr_pix", 32'(ram_rdaddress), 32'(pix_index));
            end
            prev_rd = pix_rd;
            exp_rgb = shadow[pix_index];
            if (ram_wren) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    nv = merge(e, shadow[e[19:12]]);
                    check("wraddr", 32'(ram_wraddress), 32'(e[19:12]));
                    check("wrdata", ram_data, {8'h00, nv});
                    check("byteena", 32'(ram_byteena), 32'h7);
                    shadow[e[19:12]] = nv;
                    pending--;
                    wr_count++;
                    last_wr_addr = ram_wraddress;
                    last_wr_data = ram_data;
                end
            end
            if (reg_wr) begin
                if (reg_addr == 8'h83) begin
                    m_bank = reg_data[15:13];
                    m_loct = reg_data[9];
                end else if (reg_addr[7:5] == 3'b110) begin
                    // Stimulus only exceeds FIFO_DEPTH pending while one entry is parked in the FSM.
                    if (pending <= FIFO_DEPTH) begin
                        exp_q.push_back({m_loct, m_bank, reg_addr[4:0], reg_data[11:0]});
                        pending++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [15:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_data = d;
        tick(1);
        reg_wr = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (pending != 0 && k < 300) begin tick(1); k++; end
        if (pending != 0) check("drain_timeout", 32'(pending), 32'd0);
        tick(2);
    endtask

    initial begin
        int w0, pv0, r, rd_pct;
        tick(3);
        ram_clear = 1'b0;
        reset = 1'b0;
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);

        // LOCT=0 expansion and lookup
        reg_write(8'hC5, 16'h0F3A);
        drain();
        check("c05_addr", 32'(last_wr_addr), 32'h05);
        check("c05_data", last_wr_data, 32'h00FF33AA);
        pix_rd = 1'b1; pix_index = 8'h05;
        tick(1);
        pix_rd = 1'b0;
        tick(2);
        check("c05_lookup", 32'(last_rgb), 32'hFF33AA);

        // LOCT=1 merge with the existing entry
        reg_write(8'h83, 16'h0200);
        reg_write(8'hC5, 16'h01C2);
        drain();
        check("c05_loct", last_wr_data, 32'h00F13CA2);

        // bank 7, write held off by 10 pixel reads
        reg_write(8'h83, 16'hE000);
        w0 = wr_count; pv0 = n_pv;
        pix_rd = 1'b1; pix_index = 8'h05;
        reg_wr = 1'b1; reg_addr = 8'hDF; reg_data = 16'h0123;
        tick(1);
        reg_wr = 1'b0;
        for (int i = 0; i < 9; i++) begin pix_index = 8'($urandom); tick(1); end
        check("held_no_write", 32'(wr_count - w0), 32'd0);
        pix_rd = 1'b0;
        drain();
        check("c1f_addr", 32'(last_wr_addr), 32'hFF);
        check("c1f_data", last_wr_data, 32'h00112233);
        check("held_pix_valid_cnt", 32'(n_pv - pv0), 32'd10);

        // overflow: one entry parked in the FSM, four queued, fifth dropped
        reg_write(8'h83, 16'h0000);
        w0 = wr_count;
        pix_rd = 1'b1;
        reg_write(8'hC1, 16'h0111);
        tick(1);
        for (int i = 0; i < 5; i++) reg_write(8'($unsigned(8'hC8 + i)), 16'($unsigned(16'h0A00 + i)));
        tick(3);
        check("ovf_set", 32'(ovf), 32'd1);
        pix_rd = 1'b0;
        drain();
        check("ovf_write_cnt", 32'(wr_count - w0), 32'd5);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // reset while parked in WR with a pixel read pending
        w0 = wr_count;
        pix_rd = 1'b1;
        reg_write(8'hC3, 16'h0777);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0; pix_rd = 1'b0;
        check("rst_mid_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_mid_ovf", 32'(ovf), 32'd0);
        tick(10);
        check("rst_mid_no_write", 32'(wr_count - w0), 32'd0);

        // randomized traffic
        rd_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                r = $urandom_range(0, 2);
                rd_pct = (r == 0) ? 20 : (r == 1) ? 50 : 90;
            end
            pix_rd    = ($urandom_range(0, 99) < rd_pct);
            pix_index = 8'($urandom);
            reg_wr    = 1'b0;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                reg_wr = 1'b1; reg_addr = 8'h83; reg_data = 16'($urandom);
            end else if (r < 6 && pending < FIFO_DEPTH) begin
                reg_wr = 1'b1; reg_addr = {3'b110, 5'($urandom)}; reg_data = 16'($urandom);
            end else if (r == 6) begin
                reg_wr = 1'b1; reg_addr = {4'h8, 4'($urandom_range(4, 15))}; reg_data = 16'($urandom);
            end
            tick(1);
        end
        reg_wr = 1'b0; pix_rd = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
